uart_hex_display_ctrl: RTL and testbench

Parametrised successor to the host_display byte-to-7-segment path. It accepts received bytes over a valid/ready handshake and shifts each byte in as two hex digits, so the display holds an N-digit right-justified hex history. It multiplexes the digits onto a common segment bus, with a blanking interval between digits to suppress ghosting. It sits between the UART receiver and the LogicStart 7-segment/LED pins.

---
 rtl/uart_hex_display_ctrl.sv | 149 ++++++++++++++
 tb/tb_uart_hex_display_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_display_ctrl.sv
// -----------------------------------------------------------------------------
// uart_hex_display_ctrl
//   Takes received bytes over a valid/ready handshake and shifts each one in as
//   two hex digits, so the display holds a right-justified hex history of the
//   most recent bytes. The digits are time-multiplexed onto one shared,
//   active-low segment bus. Each digit slot opens with a blanking interval
//   (all digits off) so the previous digit's pattern cannot ghost onto the
//   next one.
//
//   Optional build macro: UNWRITTEN_BLANK_EN
//     defined   - digits not yet written since reset/clear stay dark (8'hFF).
//     undefined - every digit shows its nibble, so zeros are shown as '0'.
//
// Ports
//   clk_in        in   1           system clock, rising edge
//   rst           in   1           synchronous active-high reset
//   in_data       in   8           received byte
//   in_valid      in   1           in_data valid this cycle
//   in_ready      out  1           byte can be accepted this cycle
//   segments      out  8           active-low {dp,g,f,e,d,c,b,a}
//   digit_select  out  NUM_DIGITS  active-low one-hot enable, bit 0 rightmost
//   leds          out  8           last accepted non-clear byte
// -----------------------------------------------------------------------------
module uart_hex_display_ctrl #(
   parameter int         NUM_DIGITS   = 4,     // even, >= 2
   parameter int         SCAN_DIV     = 8000,  // cycles per digit slot
   parameter int         BLANK_CYCLES = 64,    // 1 .. SCAN_DIV-1
   parameter logic [7:0] CLEAR_CODE   = 8'h0A
) (
   input  logic                  clk_in,
   input  logic                  rst,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [7:0]            segments,
   output logic [NUM_DIGITS-1:0] digit_select,
   output logic [7:0]            leds
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [0:0] S_BLANK = 1'b0;
   localparam logic [0:0] S_DRIVE = 1'b1;

   localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   logic [NUM_DIGITS-1:0][3:0] digits;
   logic [CW-1:0]              slot_cnt, slot_cnt_nxt;
   logic [IW-1:0]              idx, idx_nxt;
   logic [0:0]                 state, state_nxt;
   logic                       accept, clear_hit;
   logic                       dark;

   assign accept    = in_valid & in_ready;
   assign clear_hit = accept && (in_data == CLEAR_CODE);

   // Active-low 7-segment pattern with dp forced off.
   function automatic logic [7:0] encode(input logic [3:0] n);
      logic [6:0] p;
      case (n)
         4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
         4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
         4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
         4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
      endcase
      return {1'b1, ~p};
   endfunction

   // Scan FSM next state. Outputs are registered from the *next* state so the
   // pins change exactly on the slot boundary edge.
   always_comb begin
      slot_cnt_nxt = (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
      idx_nxt      = idx;
      state_nxt    = state;
      case (state)
         S_BLANK: if (slot_cnt == BLANK_LAST) state_nxt = S_DRIVE;
         default: if (slot_cnt == SLOT_LAST) begin
            state_nxt = S_BLANK;
            idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end
      endcase
   end

`ifdef UNWRITTEN_BLANK_EN
   localparam int FW = $clog2(NUM_DIGITS + 1);
   localparam logic [FW-1:0] FILL_MAX = FW'(NUM_DIGITS);

   // Number of digits written since reset/clear; saturates at NUM_DIGITS.
   logic [FW-1:0] fill;

   always_comb begin
      dark = (int'(idx_nxt) >= int'(fill));
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         fill <= '0;
      end else if (clear_hit) begin
         fill <= '0;
      end else if (accept) begin
         fill <= (fill >= FILL_MAX - FW'(2)) ? FILL_MAX : fill + FW'(2);
      end
   end
`else
   always_comb begin
      dark = 1'b0;
   end
`endif

   always_ff @(posedge clk_in) begin
      if (rst) begin
         in_ready     <= 1'b0;
         segments     <= 8'hFF;
         digit_select <= '1;
         leds         <= 8'h00;
         digits       <= '0;
         slot_cnt     <= '0;
         idx          <= '0;
         state        <= S_BLANK;
      end else begin
         in_ready <= 1'b1;
         slot_cnt <= slot_cnt_nxt;
         idx      <= idx_nxt;
         state    <= state_nxt;

         // Segments are built from the digit register as it stands before this
         // edge, so a byte accepted now reaches the pins one edge later.
         if (state_nxt == S_DRIVE) begin
            digit_select <= ~(NUM_DIGITS'(1) << idx_nxt);
            segments     <= dark ? 8'hFF : encode(digits[idx_nxt]);
         end else begin
            digit_select <= '1;
            segments     <= 8'hFF;
         end

         if (clear_hit) begin
            digits <= '0;
         end else if (accept) begin
            // Shift up two nibbles; the new byte lands in digits[1:0].
            digits <= (digits << 8) | (4*NUM_DIGITS)'(in_data);
            leds   <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_uart_hex_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_hex_display_ctrl
//   Scoreboard bench for uart_hex_display_ctrl (NUM_DIGITS=4, SCAN_DIV=8,
//   BLANK_CYCLES=2). Stimulus pushes the expected segments/leds per digit
//   slot; a negedge monitor pops and compares at the start of each drive slot.
// -----------------------------------------------------------------------------
module tb_uart_hex_display_ctrl;

   localparam int ND = 4;

`ifdef UNWRITTEN_BLANK_EN
   localparam logic [7:0] ZD = 8'hFF;   // unwritten digit
`else
   localparam logic [7:0] ZD = 8'hC0;   // '0'
`endif

   logic          clk_in = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [7:0]    segments;
   logic [ND-1:0] digit_select;
   logic [7:0]    leds;

   uart_hex_display_ctrl #(
      .NUM_DIGITS(ND), .SCAN_DIV(8), .BLANK_CYCLES(2), .CLEAR_CODE(8'h0A)
   ) dut (
      .clk_in(clk_in), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .segments(segments), .digit_select(digit_select),
      .leds(leds)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int         idx;
      logic [7:0] seg;
      logic [7:0] led;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   passed = 0;
   int   onehot_viol = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
   endtask

   // Expected frame: s3..s0 are the segment bytes for digits 3..0.
   task automatic push_frame(input logic [7:0] s3, s2, s1, s0, input logic [7:0] l);
      exp_t e;
      e.led = l;
      e.idx = 0; e.seg = s0; sb.push_back(e);
      e.idx = 1; e.seg = s1; sb.push_back(e);
      e.idx = 2; e.seg = s2; sb.push_back(e);
      e.idx = 3; e.seg = s3; sb.push_back(e);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(posedge clk_in);
         n++;
      end
      if (sb.size() > 0) begin
         total++;
         $display("FAIL %s timeout: %0d slot checks never seen", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk_in);
      in_data  = b;
      in_valid = 1'b1;
      chk("in_ready_send", {31'd0, in_ready}, 32'd1);
      @(negedge clk_in);
      in_valid = 1'b0;
   endtask

   // Monitor: checks the first cycle of every drive slot against the queue head.
   logic [ND-1:0] prev_sel = '1;
   always @(negedge clk_in) begin
      int z;
      int nz;
      z = -1;
      nz = 0;
      for (int i = 0; i < ND; i++) if (!digit_select[i]) begin z = i; nz++; end
      if (nz > 1) onehot_viol++;
      if (prev_sel == '1 && nz == 1 && sb.size() > 0 && sb[0].idx == z) begin
         exp_t e;
         e = sb.pop_front();
         chk($sformatf("seg_d%0d", z), {24'd0, segments}, {24'd0, e.seg});
         chk($sformatf("leds_d%0d", z), {24'd0, leds}, {24'd0, e.led});
      end
      prev_sel = digit_select;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int n;
      logic [ND-1:0] es;

      // Reset values
      repeat (3) @(negedge clk_in);
      chk("rst_segments", {24'd0, segments}, 32'hFF);
      chk("rst_digit_select", {28'd0, digit_select}, 32'hF);
      chk("rst_leds", {24'd0, leds}, 32'h00);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;

      // Scan sequence over two frames: 2 blank + 6 drive per slot.
      bad = 0;
      for (int t = 0; t < 64; t++) begin
         es = ((t % 8) < 2) ? 4'b1111 : ~(4'b0001 << ((t % 32) / 8));
         if (digit_select !== es) bad++;
         if (t == 1) chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
         @(negedge clk_in);
      end
      chk("scan_seq_errors", bad, 0);

      // Idle frame after reset
      @(posedge clk_in);
      push_frame(ZD, ZD, ZD, ZD, 8'h00);
      drain("idle");

      // D9 then 32 -> d,9,3,2
      send(8'hD9); send(8'h32);
      @(posedge clk_in);
      push_frame(8'hA1, 8'h90, 8'hB0, 8'hA4, 8'h32);
      drain("d932");

      // Clear; leds unchanged
      send(8'h0A);
      @(posedge clk_in);
      push_frame(ZD, ZD, ZD, ZD, 8'h32);
      drain("clear");

      // A3 alone: upper digits untouched since clear
      send(8'hA3);
      @(posedge clk_in);
      push_frame(ZD, ZD, 8'h88, 8'hB0, 8'hA3);
      drain("a3");

      send(8'h21);
      @(posedge clk_in);
      push_frame(8'h88, 8'hB0, 8'hA4, 8'hF9, 8'h21);
      drain("a321");

      // Back-to-back 12,34,56 with in_valid held high
      @(negedge clk_in);
      in_valid = 1'b1;
      in_data = 8'h12;
      @(negedge clk_in);
      in_data = 8'h34;
      @(negedge clk_in);
      in_data = 8'h56;
      @(negedge clk_in);
      in_valid = 1'b0;
      @(posedge clk_in);
      push_frame(8'hB0, 8'h99, 8'h92, 8'h82, 8'h56);
      drain("b2b");

      // Reset mid-drive on digit 2
      n = 0;
      while (digit_select !== 4'b1011 && n < 100) begin
         @(negedge clk_in);
         n++;
      end
      chk("reach_digit2", {28'd0, digit_select}, 32'hB);
      @(negedge clk_in);
      rst = 1'b1;
      @(negedge clk_in);
      rst = 1'b0;
      chk("mid_rst_segments", {24'd0, segments}, 32'hFF);
      chk("mid_rst_digit_select", {28'd0, digit_select}, 32'hF);
      chk("mid_rst_leds", {24'd0, leds}, 32'h00);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk_in);
      chk("post_rst_blank", {28'd0, digit_select}, 32'hF);
      @(negedge clk_in);
      chk("post_rst_idx0", {28'd0, digit_select}, 32'hE);
      @(posedge clk_in);
      push_frame(ZD, ZD, ZD, ZD, 8'h00);
      drain("post_rst");

      chk("onehot_violations", onehot_viol, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
